// File: rtl/dram_access_arbiter.sv
// dram_access_arbiter
// Shares a single-port data RAM between the CPU datapath and an external host
// loader. It sequences the LOAD / RUN / DONE run phases and drives the
// proc_enable start level into the microcoded control unit. Each RAM access is
// a fixed 4-cycle IDLE -> ISSUE -> CAPT -> ACK sequence. Round-robin
// arbitration resolves cycles where both ports request.

module dram_access_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,

  // CPU port
  input  logic              cpu_rd_req,
  input  logic              cpu_wr_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,

  // Host loader port
  input  logic              host_rd_req,
  input  logic              host_wr_req,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_ack,

  // Run-phase sequencing
  input  logic              host_load_done,
  input  logic              host_restart,
  input  logic              proc_finish,
  output logic              proc_enable,

  // RAM drive
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,

  // Status
  output logic [1:0]        phase,
  output logic              err
);

  typedef enum logic [1:0] {
    PH_LOAD = 2'b00,
    PH_RUN  = 2'b01,
    PH_DONE = 2'b10
  } phase_e;

  typedef enum logic [1:0] {
    AC_IDLE  = 2'b00,
    AC_ISSUE = 2'b01,
    AC_CAPT  = 2'b10,
    AC_ACK   = 2'b11
  } acc_e;

  typedef enum logic {
    PORT_HOST = 1'b0,
    PORT_CPU  = 1'b1
  } port_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  phase_e            phase_q;
  phase_e            phase_d;
  acc_e              acc_q;
  acc_e              acc_d;

  port_e             win_q;          // port owning the access in flight
  port_e             last_grant_q;   // port served by the last completed access
  logic              lat_we_q;
  logic [ADDR_W-1:0] lat_addr_q;
  logic [DATA_W-1:0] lat_wdata_q;

  logic              load_pend_q;
  logic              restart_pend_q;
  logic              err_q;
  logic              proc_enable_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] host_rdata_q;

  // ---------------------------------------------------------------------------
  // Request qualification
  // ---------------------------------------------------------------------------
  logic cpu_req;
  logic host_req;
  logic cpu_elig;
  logic in_idle;

  assign cpu_req  = cpu_rd_req | cpu_wr_req;
  assign host_req = host_rd_req | host_wr_req;
  // The CPU may only touch the RAM while the convolution is running.
  assign cpu_elig = cpu_req & (phase_q == PH_RUN);
  assign in_idle  = (acc_q == AC_IDLE);

  logic              grant_valid;
  port_e             grant_port;
  logic              sel_we;
  logic              sel_conflict;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Choose the winner among eligible requesters; on a tie the port not served
  // last wins, so a waiting loser is always served on the very next access.
  // NOTE: every signal assigned in a combinational block gets a default first,
  // otherwise a path that skips the assignment infers a latch.
  always_comb begin
    grant_valid = 1'b0;
    grant_port  = PORT_HOST;
    if (cpu_elig && host_req) begin
      grant_valid = 1'b1;
      grant_port  = (last_grant_q == PORT_HOST) ? PORT_CPU : PORT_HOST;
    end else if (cpu_elig) begin
      grant_valid = 1'b1;
      grant_port  = PORT_CPU;
    end else if (host_req) begin
      grant_valid = 1'b1;
      grant_port  = PORT_HOST;
    end
  end

  // Steer the winner's request fields; rd+wr together resolves to a write.
  always_comb begin
    if (grant_port == PORT_CPU) begin
      sel_we       = cpu_wr_req;
      sel_conflict = cpu_rd_req & cpu_wr_req;
      sel_addr     = cpu_addr;
      sel_wdata    = cpu_wdata;
    end else begin
      sel_we       = host_wr_req;
      sel_conflict = host_rd_req & host_wr_req;
      sel_addr     = host_addr;
      sel_wdata    = host_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Access FSM
  // ---------------------------------------------------------------------------

  // Next access state: fixed 4-cycle walk once a winner is sampled in IDLE.
  always_comb begin
    acc_d = acc_q;
    unique case (acc_q)
      AC_IDLE:  if (grant_valid) acc_d = AC_ISSUE;
      AC_ISSUE: acc_d = AC_CAPT;
      AC_CAPT:  acc_d = AC_ACK;
      AC_ACK:   acc_d = AC_IDLE;
      default:  acc_d = AC_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Phase FSM
  // ---------------------------------------------------------------------------
  logic load_evt;
  logic restart_evt;

  // A sequencing pulse that lands mid-access is replayed from its pending bit.
  assign load_evt    = host_load_done | load_pend_q;
  assign restart_evt = host_restart   | restart_pend_q;

  // Next phase: transitions are taken only between accesses.
  always_comb begin
    phase_d = phase_q;
    if (in_idle) begin
      unique case (phase_q)
        PH_LOAD: if (load_evt)    phase_d = PH_RUN;
        PH_RUN:  if (proc_finish) phase_d = PH_DONE;
        PH_DONE: if (restart_evt) phase_d = PH_LOAD;
        default: phase_d = PH_LOAD;
      endcase
    end
  end

  // State registers for both FSMs, the pending pulse bits and proc_enable.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q          <= AC_IDLE;
      phase_q        <= PH_LOAD;
      load_pend_q    <= 1'b0;
      restart_pend_q <= 1'b0;
      proc_enable_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      phase_q <= phase_d;
      if (in_idle) begin
        // Consumed here, or irrelevant to the current phase and dropped.
        load_pend_q    <= 1'b0;
        restart_pend_q <= 1'b0;
      end else begin
        load_pend_q    <= load_pend_q    | host_load_done;
        restart_pend_q <= restart_pend_q | host_restart;
      end
      // High from the second RUN cycle; low already in the first DONE cycle.
      proc_enable_q <= (phase_q == PH_RUN) && (phase_d == PH_RUN);
    end
  end

  // ---------------------------------------------------------------------------
  // Access datapath
  // ---------------------------------------------------------------------------

  // Latch the winner's request in IDLE so the requester's bus may change
  // freely once the access has been accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q       <= PORT_HOST;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
    end else if (in_idle && grant_valid) begin
      win_q       <= grant_port;
      lat_we_q    <= sel_we;
      lat_addr_q  <= sel_addr;
      lat_wdata_q <= sel_wdata;
    end
  end

  // Capture RAM read data for the winner in CAPT; writes leave rdata alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else if (acc_q == AC_CAPT && !lat_we_q) begin
      if (win_q == PORT_CPU) cpu_rdata_q  <= ram_rdata;
      else                   host_rdata_q <= ram_rdata;
    end
  end

  // Round-robin history and the sticky protocol-error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= PORT_HOST;
      err_q        <= 1'b0;
    end else begin
      if (acc_q == AC_ACK) last_grant_q <= win_q;
      // Conflicting rd+wr on the winner, or the host touching the RAM while
      // the control unit has finished but the phase has not yet left RUN.
      if (in_idle && grant_valid && sel_conflict) err_q <= 1'b1;
      if (in_idle && host_req && phase_q == PH_RUN && proc_finish) err_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ram_en      = (acc_q == AC_ISSUE);
  assign ram_we      = ram_en & lat_we_q;
  assign ram_addr    = lat_addr_q;
  assign ram_wdata   = lat_wdata_q;

  assign cpu_ack     = (acc_q == AC_ACK) && (win_q == PORT_CPU);
  assign host_ack    = (acc_q == AC_ACK) && (win_q == PORT_HOST);
  assign cpu_rdata   = cpu_rdata_q;
  assign host_rdata  = host_rdata_q;

  assign proc_enable = proc_enable_q;
  assign phase       = phase_q;
  assign err         = err_q;

endmodule

// File: tb/tb_dram_access_arbiter.sv
// Directed bench for dram_access_arbiter: host preload, CPU blocking in LOAD,
// round-robin contention, deferred phase change, DONE readback, rd+wr error
// and reset mid-access. A small RAM model answers one cycle after ram_en.

module tb_dram_access_arbiter;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_rd_req, cpu_wr_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              cpu_ack;
  logic              host_rd_req, host_wr_req;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata, host_rdata;
  logic              host_ack;
  logic              host_load_done, host_restart, proc_finish, proc_enable;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata = '0;
  logic [1:0]        phase;
  logic              err;

  logic [7:0] mem [0:255] = '{default: 8'h00};

  int total = 0;
  int bad   = 0;

  dram_access_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_rd_req     (cpu_rd_req),
    .cpu_wr_req     (cpu_wr_req),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_rdata      (cpu_rdata),
    .cpu_ack        (cpu_ack),
    .host_rd_req    (host_rd_req),
    .host_wr_req    (host_wr_req),
    .host_addr      (host_addr),
    .host_wdata     (host_wdata),
    .host_rdata     (host_rdata),
    .host_ack       (host_ack),
    .host_load_done (host_load_done),
    .host_restart   (host_restart),
    .proc_finish    (proc_finish),
    .proc_enable    (proc_enable),
    .ram_en         (ram_en),
    .ram_we         (ram_we),
    .ram_addr       (ram_addr),
    .ram_wdata      (ram_wdata),
    .ram_rdata      (ram_rdata),
    .phase          (phase),
    .err            (err)
  );

  always #5 clk = ~clk;

  // Single-port RAM model: read data appears the cycle after ram_en.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr[7:0]];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Ticks until the selected ack is seen (bounded); cycles = -1 on timeout.
  task automatic wait_ack(input bit is_cpu, output int cycles, output int en_cycles);
    cycles    = -1;
    en_cycles = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (ram_en === 1'b1) en_cycles++;
      if ((is_cpu ? cpu_ack : host_ack) === 1'b1) begin
        cycles = i;
        break;
      end
    end
  endtask

  // One host access starting in an IDLE cycle; ends in the next IDLE cycle.
  task automatic host_access(input string tag, input bit we, input logic [15:0] addr,
                             input logic [7:0] wd, input logic [7:0] exp_rd, input bit chk_rd);
    int lat, en;
    host_addr   = addr;
    host_wdata  = wd;
    host_wr_req = we;
    host_rd_req = !we;
    wait_ack(1'b0, lat, en);
    host_rd_req = 1'b0;
    host_wr_req = 1'b0;
    check({tag, " latency"}, lat, 3);
    check({tag, " ram_en cycles"}, en, 1);
    if (chk_rd) check({tag, " rdata"}, host_rdata, exp_rd);
    tick();
  endtask

  int lat, en, nacks;
  int ack_cyc [4];
  logic ack_cpu [4];

  initial begin
    rst = 1'b1;
    cpu_rd_req = 0; cpu_wr_req = 0; cpu_addr = '0; cpu_wdata = '0;
    host_rd_req = 0; host_wr_req = 0; host_addr = '0; host_wdata = '0;
    host_load_done = 0; host_restart = 0; proc_finish = 0;

    // ---- reset state ----
    repeat (3) tick();
    check("rst phase", phase, 2'b00);
    check("rst proc_enable", proc_enable, 0);
    check("rst err", err, 0);
    check("rst ram_en", ram_en, 0);
    check("rst ram_we", ram_we, 0);
    check("rst ram_addr", ram_addr, 0);
    check("rst ram_wdata", ram_wdata, 0);
    check("rst acks", {cpu_ack, host_ack}, 0);
    check("rst rdata", {cpu_rdata, host_rdata}, 0);
    rst = 1'b0;
    tick();

    // ---- host preload in LOAD ----
    host_access("h_wr10", 1'b1, 16'h0010, 8'hA5, 8'h00, 1'b0);
    host_access("h_wr00", 1'b1, 16'h0000, 8'h3C, 8'h00, 1'b0);
    host_access("h_rd10", 1'b0, 16'h0010, 8'h00, 8'hA5, 1'b1);
    check("preload mem10", mem[8'h10], 8'hA5);
    check("preload phase", phase, 2'b00);

    // ---- CPU blocked in LOAD, released by host_load_done ----
    cpu_addr = 16'h0000;
    cpu_rd_req = 1'b1;
    nacks = 0; en = 0;
    repeat (20) begin
      tick();
      if (cpu_ack === 1'b1) nacks++;
      if (ram_en === 1'b1) en++;
    end
    check("cpu blocked acks", nacks, 0);
    check("cpu blocked ram_en", en, 0);
    host_load_done = 1'b1;
    tick();
    host_load_done = 1'b0;
    check("load_done phase", phase, 2'b01);
    check("proc_enable first RUN cycle", proc_enable, 0);
    tick();
    check("proc_enable second RUN cycle", proc_enable, 1);
    wait_ack(1'b1, lat, en);
    cpu_rd_req = 1'b0;
    check("cpu ack 4 cycles after load_done", lat, 2);
    check("cpu rdata", cpu_rdata, 8'h3C);
    tick();

    // ---- host-only access in RUN, leaves last_grant = HOST ----
    host_access("h_rd_run", 1'b0, 16'h0010, 8'h00, 8'hA5, 1'b1);
    check("run err clean", err, 0);

    // ---- contention: both request continuously ----
    cpu_addr = 16'h0000; cpu_rd_req = 1'b1;
    host_addr = 16'h0010; host_rd_req = 1'b1;
    nacks = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (cpu_ack === 1'b1 || host_ack === 1'b1) begin
        if (nacks < 4) begin
          ack_cpu[nacks] = cpu_ack;
          ack_cyc[nacks] = i;
        end
        nacks++;
      end
    end
    cpu_rd_req = 1'b0;
    host_rd_req = 1'b0;
    check("contention ack count", nacks, 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("contention grant%0d is_cpu", k), ack_cpu[k], (k % 2 == 0));
      check($sformatf("contention grant%0d cycle", k), ack_cyc[k], 3 + 4 * k);
    end
    tick();
    check("contention cpu rdata", cpu_rdata, 8'h3C);
    check("contention host rdata", host_rdata, 8'hA5);

    // ---- proc_finish -> DONE, readback, restart -> LOAD ----
    proc_finish = 1'b1;
    tick();
    check("finish phase", phase, 2'b10);
    check("finish proc_enable", proc_enable, 0);
    host_access("h_rd_done", 1'b0, 16'h0000, 8'h00, 8'h3C, 1'b1);
    check("done err clean", err, 0);
    host_restart = 1'b1;
    tick();
    host_restart = 1'b0;
    proc_finish = 1'b0;
    check("restart phase", phase, 2'b00);

    // ---- host_load_done during ISSUE of a host write ----
    host_addr = 16'h0030; host_wdata = 8'h5A; host_wr_req = 1'b1;
    tick();
    check("deferred ram_en in ISSUE", ram_en, 1);
    host_load_done = 1'b1;
    tick();
    host_load_done = 1'b0;
    tick();
    check("deferred write ack", host_ack, 1);
    check("deferred phase at ack", phase, 2'b00);
    host_wr_req = 1'b0;
    tick();
    tick();
    check("deferred phase after idle", phase, 2'b01);
    check("deferred mem30", mem[8'h30], 8'h5A);

    // ---- CPU rd+wr together in RUN ----
    check("err before conflict", err, 0);
    cpu_addr = 16'h0040; cpu_wdata = 8'h77;
    cpu_rd_req = 1'b1; cpu_wr_req = 1'b1;
    tick();
    check("conflict ram_we", ram_we, 1);
    wait_ack(1'b1, lat, en);
    cpu_rd_req = 1'b0; cpu_wr_req = 1'b0;
    check("conflict ack latency", lat, 2);
    check("conflict cpu rdata unchanged", cpu_rdata, 8'h3C);
    check("conflict err", err, 1);
    check("conflict mem40", mem[8'h40], 8'h77);
    repeat (5) tick();
    check("err sticky", err, 1);

    // ---- reset during CAPT of a host read ----
    host_addr = 16'h0010; host_rd_req = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    host_rd_req = 1'b0;
    check("abort ram_en", ram_en, 0);
    check("abort acks", {cpu_ack, host_ack}, 0);
    check("abort phase", phase, 2'b00);
    check("abort err", err, 0);
    check("abort proc_enable", proc_enable, 0);
    check("abort rdata", {cpu_rdata, host_rdata}, 0);
    check("abort ram drive", {ram_we, ram_addr, ram_wdata}, 0);
    nacks = 0;
    tick();
    rst = 1'b0;
    repeat (3) begin
      tick();
      if (cpu_ack === 1'b1 || host_ack === 1'b1) nacks++;
    end
    check("abort no late ack", nacks, 0);

    // ---- host request in RUN after proc_finish rose ----
    host_load_done = 1'b1;
    tick();
    host_load_done = 1'b0;
    check("rerun phase", phase, 2'b01);
    proc_finish = 1'b1;
    host_access("h_rd_finish", 1'b0, 16'h0010, 8'h00, 8'hA5, 1'b1);
    check("late host err", err, 1);
    check("late host phase", phase, 2'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
